// File: rtl/pass_switch_arbiter_pkg.sv
// Shared definitions for the pass-switch bus arbiter: FSM state encoding,
// parameter defaults and a small sizing helper.
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
package pass_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        OWN   = 2'd2,
        BREAK = 2'd3
    } arb_state_t;

    localparam int N_DEF       = 4;
    localparam int SETTLE_DEF  = 1;
    localparam int DEAD_DEF    = 2;
    localparam int TIMEOUT_DEF = 64;

    // Largest of three values, used to size the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pass_switch_arbiter_if.sv
// Request/grant bundle between requester control logic and the arbiter.
// master = requester side (drives req), slave = arbiter side.
// Purely structural, no logic or latency.
interface pass_switch_arbiter_if
    import pass_bus_pkg::*;
#(
    parameter int N = N_DEF
) ();

    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic [N-1:0] sw_en;
    logic [N-1:0] gnt;
    logic [W-1:0] owner;
    logic         busy;
    logic         timeout_err;

    modport master (
        output req,
        input  sw_en,
        input  gnt,
        input  owner,
        input  busy,
        input  timeout_err
    );

    modport slave (
        input  req,
        output sw_en,
        output gnt,
        output owner,
        output busy,
        output timeout_err
    );

endinterface

// File: rtl/pass_switch_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit strictly after ptr, wrapping.
// Zero latency; valid low when no bit of req is set.
// No backpressure: pure function of its inputs.
module rr_pick
    import pass_bus_pkg::*;
#(
    parameter  int N = N_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    localparam int IW = W + 1;

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester after
    // the pointer is the last (and therefore winning) assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, ptr} + IW'(k);
            if (cand >= IW'(N)) cand = cand - IW'(N);
            if (req[cand[W-1:0]]) begin
                valid = 1'b1;
                idx   = cand[W-1:0];
            end
        end
    end

endmodule

// File: rtl/pass_switch_arbiter.sv
// Round-robin owner sequencer for a tranif1 pass-switch bus with break-before-make.
// Latency: sw_en one edge after a winning req, gnt SETTLE edges later; DEAD+1 off cycles between owners.
// Backpressure: level req only; others wait in req until IDLE. Macro ARB_TIMEOUT_EN adds forced release.
module pass_switch_arbiter
    import pass_bus_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int DEAD    = DEAD_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    pass_switch_arbiter_if.slave bus
);

    localparam int W  = $clog2(N);
    localparam int CW = $clog2(max3(SETTLE, DEAD, TIMEOUT) + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  owner_q, owner_d;
    logic [W-1:0]  ptr_q, ptr_d;

    logic [N-1:0]  elig;
    logic          pick_vld;
    logic [W-1:0]  pick_idx;

    logic [N-1:0]  sw_en_d;
    logic [N-1:0]  gnt_d;
    logic          busy_d;

`ifdef ARB_TIMEOUT_EN
    logic [N-1:0]  mask_q, mask_d;
    logic          force_brk;

    // An evicted requester stays ineligible until it lets go of req.
    assign elig = bus.req & ~mask_q;
`else
    assign elig = bus.req;
`endif

    rr_pick #(.N(N)) u_pick (
        .req   (elig),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // State register together with the phase counter, owner and rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= W'(N - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: abort/release on req[owner] low takes priority over phase completion.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        force_brk = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = MAKE;
                    owner_d = pick_idx;
                    ptr_d   = pick_idx;
                end
            end
            MAKE: begin
                if (!bus.req[owner_q])              state_d = BREAK;
                else if (cnt_q >= CW'(SETTLE - 1)) state_d = OWN;
            end
            OWN: begin
                if (!bus.req[owner_q]) begin
                    state_d = BREAK;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                    state_d   = BREAK;
                    force_brk = 1'b1;
                end
`endif
            end
            BREAK: begin
                if (cnt_q >= CW'(DEAD - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // One counter serves every phase: cleared on entry, saturating otherwise.
        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        else                       cnt_d = cnt_q;
    end

    // Outputs decoded from the next state so the registered copies line up with the state.
    always_comb begin
        sw_en_d = '0;
        gnt_d   = '0;
        busy_d  = (state_d != IDLE);
        if (state_d == MAKE || state_d == OWN) sw_en_d[owner_d] = 1'b1;
        if (state_d == OWN)                    gnt_d[owner_d]   = 1'b1;
    end

    // Output registers: reset opens every switch immediately, without a dead interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sw_en <= '0;
            bus.gnt   <= '0;
            bus.busy  <= 1'b0;
        end else begin
            bus.sw_en <= sw_en_d;
            bus.gnt   <= gnt_d;
            bus.busy  <= busy_d;
        end
    end

    assign bus.owner = owner_q;

`ifdef ARB_TIMEOUT_EN
    // Set the evicted owner's mask bit; clear any bit whose req is seen low.
    always_comb begin
        mask_d = mask_q & bus.req;
        if (force_brk) mask_d[owner_q] = 1'b1;
    end

    // Mask register and the one-cycle eviction pulse, aligned with BREAK entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q          <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            mask_q          <= mask_d;
            bus.timeout_err <= force_brk;
        end
    end
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_pass_switch_arbiter.sv
// Bench for pass_switch_arbiter: timestamp-based ownership model checked every
// cycle, plus directed literal checks. Define ARB_TIMEOUT_EN to cover eviction.
module tb_pass_switch_arbiter;

    localparam int NR      = 4;
    localparam int SETTLE  = 1;
    localparam int DEAD    = 2;
    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;

    pass_switch_arbiter_if #(.N(NR)) bif ();
    pass_switch_arbiter_if #(.N(NR)) bif3 ();

    pass_switch_arbiter #(.N(NR), .SETTLE(SETTLE), .DEAD(DEAD), .TIMEOUT(TIMEOUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Second instance with a long settle time, used for the abort-in-MAKE case.
    pass_switch_arbiter #(.N(NR), .SETTLE(3), .DEAD(DEAD), .TIMEOUT(TIMEOUT)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bif3)
    );

    always #5 clk = ~clk;

    // Shared bus: each requester side is a reg connected through a switch
    // closed by its sw_en bit (conditional drivers model the pass switches).
    wire  [7:0] data_bus;
    logic [7:0] side [NR];
    for (genvar g = 0; g < NR; g++) begin : g_sw
        assign data_bus = bif.sw_en[g] ? side[g] : 8'bz;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A session is described by the edge it was won (m_tmake) and the edge it
    // ended (m_trel); all outputs follow from edge arithmetic on those.
    int       m_n     = 0;
    int       m_cur   = 0;
    int       m_last  = NR - 1;
    int       m_tmake = 0;
    int       m_trel  = 0;
    int       m_to_at = -1;
    bit       m_have  = 0;
    bit       m_act   = 0;
    bit [3:0] m_mask  = 0;
    bit [3:0] m_r;
    bit       m_found;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n = 0; m_cur = 0; m_last = NR - 1; m_tmake = 0; m_trel = 0;
            m_to_at = -1; m_have = 0; m_act = 0; m_mask = 0;
        end else begin
            m_r = bif.req;
            m_n++;
            if (m_act) begin
                if (!m_r[m_cur]) begin
                    m_act = 0; m_trel = m_n;
                end
`ifdef ARB_TIMEOUT_EN
                else if (m_n - m_tmake == SETTLE + TIMEOUT) begin
                    m_act = 0; m_trel = m_n; m_mask[m_cur] = 1'b1; m_to_at = m_n;
                end
`endif
            end else if (!m_have || (m_n - m_trel > DEAD)) begin
                m_found = 0;
                for (int k = 1; k <= NR; k++) begin
                    if (!m_found && m_r[(m_last + k) % NR] && !m_mask[(m_last + k) % NR]) begin
                        m_found = 1;
                        m_cur   = (m_last + k) % NR;
                    end
                end
                if (m_found) begin
                    m_last = m_cur; m_tmake = m_n; m_have = 1; m_act = 1;
                end
            end
            m_mask = m_mask & m_r;
        end
    end

    int e_sw, e_gnt, e_busy, e_to;

    // Every-cycle comparison of all arbiter outputs against the model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            e_sw   = m_act ? (1 << m_cur) : 0;
            e_gnt  = (m_act && (m_n - m_tmake >= SETTLE)) ? (1 << m_cur) : 0;
            e_busy = (m_act || (m_have && (m_n - m_trel < DEAD))) ? 1 : 0;
            e_to   = (m_to_at == m_n) ? 1 : 0;
            chk("sw_en", bif.sw_en, e_sw);
            chk("gnt", bif.gnt, e_gnt);
            chk("owner", bif.owner, m_cur);
            chk("busy", bif.busy, e_busy);
            chk("timeout_err", bif.timeout_err, e_to);
            chk("sw_en_onehot", ($countones(bif.sw_en) <= 1) ? 1 : 0, 1);
            chk("gnt_within_sw_en", ((bif.gnt & ~bif.sw_en) == 4'b0) ? 1 : 0, 1);
            if (m_act) begin
                chk("bus_value", data_bus, side[m_cur]);
                chk("bus_known", $isunknown(data_bus) ? 1 : 0, 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bif.req  = '0;
        bif3.req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int idx);
        idx = -1;
        for (int c = 0; c < 50 && idx < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (bif.gnt[i]) idx = i;
        end
        if (idx < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_gnt: no grant within 50 cycles at %0t", $time);
        end
    endtask

    int g, cnt, gap;
    int ord [NR];

    initial begin
        side[0] = 8'hA5; side[1] = 8'h3C; side[2] = 8'h5A; side[3] = 8'hC3;
        rst = 1'b1;
        bif.req  = '0;
        bif3.req = '0;
        tick(2);
        chk("rst_sw_en", bif.sw_en, 0);
        chk("rst_gnt", bif.gnt, 0);
        chk("rst_owner", bif.owner, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_timeout_err", bif.timeout_err, 0);
        rst = 1'b0;
        tick(1);

        // Single request held five cycles.
        bif.req = 4'b0001;
        tick(1);
        chk("single_make_sw_en", bif.sw_en, 4'b0001);
        chk("single_make_gnt", bif.gnt, 4'b0000);
        tick(1);
        chk("single_own_gnt", bif.gnt, 4'b0001);
        chk("single_bus", data_bus, 8'hA5);
        tick(3);
        bif.req = 4'b0000;
        tick(1);
        chk("single_drop_sw_en", bif.sw_en, 0);
        chk("single_drop_gnt", bif.gnt, 0);
        chk("single_break_busy1", bif.busy, 1);
        tick(1);
        chk("single_break_busy2", bif.busy, 1);
        tick(1);
        chk("single_idle_busy", bif.busy, 0);
        tick(2);

        // All four requesting from reset; each drops three cycles after its grant.
        do_reset();
        bif.req = 4'b1111;
        for (int o = 0; o < NR; o++) begin
            wait_gnt(g);
            ord[o] = g;
            tick(3);
            if (g >= 0) bif.req[g] = 1'b0;
            if (o < NR - 1) begin
                gap = 0;
                for (int c = 0; c < 20; c++) begin
                    tick(1);
                    if (bif.sw_en != 0) break;
                    gap++;
                end
                chk("rr_off_gap", gap, DEAD + 1);
            end
        end
        chk("rr_order0", ord[0], 0);
        chk("rr_order1", ord[1], 1);
        chk("rr_order2", ord[2], 2);
        chk("rr_order3", ord[3], 3);
        tick(4);

        // Abort during MAKE on the SETTLE=3 instance.
        bif3.req = 4'b0100;
        tick(1);
        chk("abort_sw_en1", bif3.sw_en, 4'b0100);
        chk("abort_gnt1", bif3.gnt, 0);
        tick(1);
        chk("abort_sw_en2", bif3.sw_en, 4'b0100);
        chk("abort_gnt2", bif3.gnt, 0);
        bif3.req = 4'b0000;
        tick(1);
        chk("abort_sw_en_off", bif3.sw_en, 0);
        chk("abort_busy1", bif3.busy, 1);
        tick(1);
        chk("abort_busy2", bif3.busy, 1);
        chk("abort_gnt3", bif3.gnt, 0);
        tick(1);
        chk("abort_idle", bif3.busy, 0);

        // Asynchronous reset while requester 2 owns the bus.
        do_reset();
        bif.req = 4'b0100;
        wait_gnt(g);
        chk("areset_owner_before", g, 2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_sw_en", bif.sw_en, 0);
        chk("areset_gnt", bif.gnt, 0);
        chk("areset_busy", bif.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        bif.req = 4'b0110;
        wait_gnt(g);
        chk("areset_first_after", g, 1);
        bif.req = 4'b0000;
        tick(5);

`ifdef ARB_TIMEOUT_EN
        // Eviction after TIMEOUT cycles in OWN, then masking until req toggles.
        do_reset();
        bif.req = 4'b1010;
        wait_gnt(g);
        chk("to_first_owner", g, 1);
        cnt = 1;
        for (int c = 0; c < 40 && bif.gnt == 4'b0010; c++) begin
            tick(1);
            if (bif.gnt == 4'b0010) cnt++;
        end
        chk("to_own_cycles", cnt, TIMEOUT);
        chk("to_pulse_high", bif.timeout_err, 1);
        tick(1);
        chk("to_pulse_low", bif.timeout_err, 0);
        wait_gnt(g);
        chk("to_next_owner", g, 3);
        tick(3);
        bif.req[3] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (bif.sw_en != 0) cnt++;
        end
        chk("to_masked_no_regrant", cnt, 0);
        bif.req[1] = 1'b0;
        tick(1);
        bif.req[1] = 1'b1;
        wait_gnt(g);
        chk("to_regrant_after_toggle", g, 1);
        bif.req = 4'b0000;
        tick(5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
